// File: rtl/ex_mem_pipe_reg_if.sv
// One valid/ready channel of the EX/MEM boundary: handshake plus control and payload fields.
// A producer uses the master modport and a consumer uses the slave modport.
interface ex_mem_pipe_reg_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CTRL_W = 5
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] ra1;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] r0d;

    modport master (output valid, ctrl, ra1, alu, data, r0d, input ready);
    modport slave  (input valid, ctrl, ra1, alu, data, r0d, output ready);
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// MAIN drives the outputs and SKID absorbs one op under stall; flush drops everything held.
module ex_mem_pipe_reg #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CTRL_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    ex_mem_pipe_reg_if.slave      in_bus,
    ex_mem_pipe_reg_if.master     out_bus,
    output logic [1:0]            occupancy
);

    localparam int unsigned PayW = REG_AW + 3 * DATA_W;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [PayW-1:0]   main_pay_q, main_pay_d;
    logic [PayW-1:0]   skid_pay_q, skid_pay_d;
    logic [PayW-1:0]   in_pay;
    logic              in_ready;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;

    assign in_pay   = {in_bus.ra1, in_bus.alu, in_bus.data, in_bus.r0d};
    assign in_fire  = in_bus.valid & in_ready;
    assign out_fire = out_valid & out_bus.ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            main_pay_q  <= '0;
            skid_pay_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            main_pay_q  <= main_pay_d;
            skid_pay_q  <= skid_pay_d;
        end
    end

    // Control bits are cleared whenever an entry is vacated so a bubble never carries
    // stale write enables into MEM.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        main_pay_d  = main_pay_q;
        skid_pay_d  = skid_pay_q;
        if (flush) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d     = StOne;
                        main_ctrl_d = in_bus.ctrl;
                        main_pay_d  = in_pay;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_bus.ctrl;
                        main_pay_d  = in_pay;
                    end else if (in_fire) begin
                        state_d     = StTwo;
                        skid_ctrl_d = in_bus.ctrl;
                        skid_pay_d  = in_pay;
                    end else if (out_fire) begin
                        state_d     = StEmpty;
                        main_ctrl_d = '0;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d     = StOne;
                        main_ctrl_d = skid_ctrl_q;
                        main_pay_d  = skid_pay_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // in_ready is gated by reset so EX sees no acceptance while the buffer is held in reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: in_ready = 1'b1;
            StOne: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            StTwo: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: ;
        endcase
        in_ready = in_ready & ~flush & reset;
    end

    assign in_bus.ready  = in_ready;
    assign out_bus.valid = out_valid;
    assign out_bus.ctrl  = main_ctrl_q;
    assign {out_bus.ra1, out_bus.alu, out_bus.data, out_bus.r0d} = main_pay_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: a depth-2 FIFO queue model fed by the driver and drained by
// an independent monitor that checks every cycle.
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [3:0]  ra1;
        logic [15:0] alu;
        logic [15:0] data;
        logic [15:0] r0d;
    } item_t;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;

    ex_mem_pipe_reg_if #(.DATA_W(16), .REG_AW(4), .CTRL_W(5)) in_bus ();
    ex_mem_pipe_reg_if #(.DATA_W(16), .REG_AW(4), .CTRL_W(5)) out_bus ();

    ex_mem_pipe_reg #(.DATA_W(16), .REG_AW(4), .CTRL_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .occupancy (occupancy)
    );

    int    checks   = 0;
    int    failures = 0;
    item_t exp_q[$];
    int    exp_occ  = 0;
    logic  exp_rdy  = 1'b0;
    logic  mon_en   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic item_t mk(input logic [4:0] c, input logic [15:0] a);
        item_t it;
        it.ctrl = c;
        it.ra1  = 4'($urandom);
        it.alu  = a;
        it.data = 16'($urandom);
        it.r0d  = 16'($urandom);
        return it;
    endfunction

    function automatic item_t rnd_item();
        return mk(5'($urandom), 16'($urandom));
    endfunction

    function automatic item_t dut_out();
        item_t it;
        it = {out_bus.ctrl, out_bus.ra1, out_bus.alu, out_bus.data, out_bus.r0d};
        return it;
    endfunction

    // One cycle of stimulus; the model alone decides whether the op is accepted.
    task automatic drive(input logic v, input logic r, input logic f, input item_t it,
                         output logic acc);
        @(negedge clk);
        #1;
        in_bus.valid = v;
        {in_bus.ctrl, in_bus.ra1, in_bus.alu, in_bus.data, in_bus.r0d} = it;
        out_bus.ready = r;
        flush         = f;
        exp_occ       = exp_q.size();
        exp_rdy       = (exp_q.size() < 2) && !f;
        acc           = v && exp_rdy;
        if (acc) exp_q.push_back(it);
    endtask

    // Monitor: samples just before the rising edge, pops on a MEM handshake.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                check("occupancy", 64'(occupancy), 64'(exp_occ));
                check("out_valid", 64'(out_bus.valid), 64'(exp_occ != 0));
                check("in_ready", 64'(in_bus.ready), 64'(exp_rdy));
                if (exp_occ != 0) begin
                    check("out_payload", 64'(dut_out()), 64'(exp_q[0]));
                    if (out_bus.ready) void'(exp_q.pop_front());
                end else begin
                    check("out_ctrl_idle", 64'(out_bus.ctrl), 64'd0);
                end
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        logic  acc;
        logic  pv;
        item_t pit;
        logic  done;

        reset         = 1'b0;
        flush         = 1'b0;
        out_bus.ready = 1'b0;
        in_bus.valid  = 1'b1;
        {in_bus.ctrl, in_bus.ra1, in_bus.alu, in_bus.data, in_bus.r0d} = '0;
        in_bus.alu    = 16'h0008;

        // Held in reset with a valid op presented: nothing may be accepted or shown.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("rst_out_valid", 64'(out_bus.valid), 64'd0);
            check("rst_out_ctrl", 64'(out_bus.ctrl), 64'd0);
            check("rst_occupancy", 64'(occupancy), 64'd0);
            check("rst_in_ready", 64'(in_bus.ready), 64'd0);
        end

        @(negedge clk);
        #1;
        in_bus.valid = 1'b0;
        reset        = 1'b1;
        exp_occ      = 0;
        exp_rdy      = 1'b1;
        mon_en       = 1'b1;

        // Back-to-back stream with MEM always ready.
        for (int i = 1; i <= 3; i++) drive(1'b1, 1'b1, 1'b0, mk(5'b00001, 16'(i)), acc);
        drive(1'b0, 1'b1, 1'b0, rnd_item(), acc);
        drive(1'b0, 1'b1, 1'b0, rnd_item(), acc);

        // Stall fills both entries, third op refused until one drains.
        drive(1'b1, 1'b0, 1'b0, mk(5'b00001, 16'd8), acc);
        drive(1'b1, 1'b0, 1'b0, mk(5'b00001, 16'd9), acc);
        pit  = mk(5'b00001, 16'd10);
        drive(1'b1, 1'b0, 1'b0, pit, acc);
        check("third_op_refused", 64'(acc), 64'd0);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            drive(1'b1, 1'b1, 1'b0, pit, acc);
            done = acc;
        end
        check("third_op_accepted", 64'(done), 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, rnd_item(), acc);

        // Flush with two entries held and a valid op on the input.
        drive(1'b1, 1'b0, 1'b0, mk(5'b00011, 16'd8), acc);
        drive(1'b1, 1'b0, 1'b0, mk(5'b00011, 16'd9), acc);
        drive(1'b1, 1'b0, 1'b1, mk(5'b00011, 16'd11), acc);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, rnd_item(), acc);

        // Simultaneous enqueue and dequeue at occupancy 1.
        drive(1'b1, 1'b0, 1'b0, rnd_item(), acc);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, rnd_item(), acc);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, rnd_item(), acc);

        // Random traffic; an op not accepted is kept on the input.
        pv  = 1'b0;
        pit = rnd_item();
        for (int i = 0; i < 1500; i++) begin
            if (!pv) begin
                pv  = ($urandom_range(0, 3) != 0);
                pit = rnd_item();
            end
            drive(pv, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), pit, acc);
            if (acc) pv = 1'b0;
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, rnd_item(), acc);

        // Asynchronous reset in the middle of a stall.
        pit = '0;
        pit.ctrl = 5'b11111;
        pit.ra1  = 4'd7;
        pit.alu  = 16'd8;
        pit.data = 16'd9;
        pit.r0d  = 16'd10;
        drive(1'b1, 1'b0, 1'b0, pit, acc);
        drive(1'b1, 1'b0, 1'b0, rnd_item(), acc);
        @(negedge clk);
        #1;
        mon_en       = 1'b0;
        in_bus.valid = 1'b0;
        reset        = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_bus.valid), 64'd0);
        check("async_rst_payload", 64'(dut_out()), 64'd0);
        check("async_rst_occupancy", 64'(occupancy), 64'd0);
        check("async_rst_in_ready", 64'(in_bus.ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        reset   = 1'b1;
        exp_occ = 0;
        exp_rdy = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0), 1'b0,
                  rnd_item(), acc);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, rnd_item(), acc);
        @(negedge clk);
        #4;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
